// File: rtl/ysyx_210544_cache_arbiter_pkg.sv
// rtl/ysyx_210544_cache_arbiter_pkg.sv - shared encodings for the IF/MEM cache port arbiter
package ysyx_210544_cache_arbiter_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  localparam logic OWNER_IF  = 1'b0;
  localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/ysyx_210544_arb_pick.sv
// rtl/ysyx_210544_arb_pick.sv - combinational owner select between IF and MEM requests
module ysyx_210544_arb_pick
  import ysyx_210544_cache_arbiter_pkg::*;
#(
  parameter int MEM_FIRST = 1,
  parameter int RR_EN     = 1
) (
  input  logic if_req,
  input  logic mem_req,
  input  logic last_owner,
  output logic grant,
  output logic owner
);

  always_comb begin
    grant = if_req | mem_req;
    owner = OWNER_IF;
    if (if_req && mem_req) begin
      // On a tie, round-robin hands the port to whoever did not have it last
      if (RR_EN != 0) owner = ~last_owner;
      else            owner = (MEM_FIRST != 0) ? OWNER_MEM : OWNER_IF;
    end else if (mem_req) begin
      owner = OWNER_MEM;
    end
  end

endmodule

// File: rtl/ysyx_210544_cache_arbiter.sv
// rtl/ysyx_210544_cache_arbiter.sv - shares one cache core port between IF and MEM
module ysyx_210544_cache_arbiter
  import ysyx_210544_cache_arbiter_pkg::*;
#(
  parameter int MEM_FIRST = 1,
  parameter int RR_EN     = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_if_addr,
  input  logic [2:0]      i_if_bytes,
  input  logic            i_if_req,
  output logic [XLEN-1:0] o_if_rdata,
  output logic            o_if_ack,
  input  logic [XLEN-1:0] i_mem_addr,
  input  logic [XLEN-1:0] i_mem_wdata,
  input  logic [2:0]      i_mem_bytes,
  input  logic            i_mem_op,
  input  logic            i_mem_req,
  output logic [XLEN-1:0] o_mem_rdata,
  output logic            o_mem_ack,
  output logic [XLEN-1:0] o_core_addr,
  output logic [XLEN-1:0] o_core_wdata,
  output logic [2:0]      o_core_bytes,
  output logic            o_core_op,
  output logic            o_core_req,
  input  logic [XLEN-1:0] i_core_rdata,
  input  logic            i_core_ack,
  input  logic            i_arb_lock,
  output logic            o_arb_busy,
  output logic            o_arb_owner,
  output logic            o_arb_timeout,
  input  logic            i_timeout_clr
);

  localparam logic [9:0] WD_LAST = 10'(TIMEOUT - 1);

  arb_state_t      state, state_nxt;
  logic            owner_q, core_req_q, op_q, timeout_q;
  logic [XLEN-1:0] addr_q, wdata_q, if_rdata_q, mem_rdata_q;
  logic [2:0]      bytes_q;
  logic [9:0]      wd_cnt;
  logic            pick_valid, pick_owner, grant;

  ysyx_210544_arb_pick #(
    .MEM_FIRST(MEM_FIRST),
    .RR_EN    (RR_EN)
  ) u_pick (
    .if_req    (i_if_req),
    .mem_req   (i_mem_req),
    .last_owner(owner_q),
    .grant     (pick_valid),
    .owner     (pick_owner)
  );

  // Lock only gates new grants; an access already past IDLE always completes
  assign grant = (state == ARB_IDLE) && !i_arb_lock && pick_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (grant) state_nxt = ARB_ISSUE;
      ARB_ISSUE: state_nxt = ARB_WAIT;
      ARB_WAIT:  if (i_core_ack) state_nxt = ARB_RESP;
      ARB_RESP:  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    o_if_ack   = 1'b0;
    o_mem_ack  = 1'b0;
    if (state == ARB_RESP) begin
      o_if_ack  = (owner_q == OWNER_IF);
      o_mem_ack = (owner_q == OWNER_MEM);
    end
    o_arb_busy = (state != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWNER_IF;
      core_req_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bytes_q     <= '0;
      op_q        <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= pick_owner;
        if (pick_owner == OWNER_MEM) begin
          addr_q  <= i_mem_addr;
          wdata_q <= i_mem_wdata;
          bytes_q <= i_mem_bytes;
          op_q    <= i_mem_op;
        end else begin
          addr_q  <= i_if_addr;
          wdata_q <= '0;
          bytes_q <= i_if_bytes;
          op_q    <= 1'b0;
        end
      end
      if (state == ARB_ISSUE) begin
        core_req_q <= 1'b1;
      end else if (state == ARB_WAIT && i_core_ack) begin
        core_req_q <= 1'b0;
        if (owner_q == OWNER_MEM) mem_rdata_q <= i_core_rdata;
        else                      if_rdata_q  <= i_core_rdata;
      end
    end
  end

  // Watchdog flags once per WAIT on the crossing; clear beats a same-cycle set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ARB_WAIT) begin
        if (wd_cnt != '1) wd_cnt <= wd_cnt + 10'd1;
      end else begin
        wd_cnt <= '0;
      end
      if (i_timeout_clr)                             timeout_q <= 1'b0;
      else if (state == ARB_WAIT && wd_cnt == WD_LAST) timeout_q <= 1'b1;
    end
  end

  assign o_core_addr   = addr_q;
  assign o_core_wdata  = wdata_q;
  assign o_core_bytes  = bytes_q;
  assign o_core_op     = op_q;
  assign o_core_req    = core_req_q;
  assign o_if_rdata    = if_rdata_q;
  assign o_mem_rdata   = mem_rdata_q;
  assign o_arb_owner   = owner_q;
  assign o_arb_timeout = timeout_q;

endmodule

// File: tb/tb_ysyx_210544_cache_arbiter.sv
// tb/tb_ysyx_210544_cache_arbiter.sv - scoreboard bench for the IF/MEM cache port arbiter
module tb_ysyx_210544_cache_arbiter;

  localparam int BUDGET = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_if_addr, i_mem_addr, i_mem_wdata, i_core_rdata;
  logic [2:0]  i_if_bytes, i_mem_bytes;
  logic        i_if_req, i_mem_op, i_mem_req, i_core_ack, i_arb_lock, i_timeout_clr;
  logic [63:0] o_if_rdata, o_mem_rdata, o_core_addr, o_core_wdata;
  logic [2:0]  o_core_bytes;
  logic        o_if_ack, o_mem_ack, o_core_op, o_core_req, o_arb_busy, o_arb_owner, o_arb_timeout;

  ysyx_210544_cache_arbiter #(.MEM_FIRST(1), .RR_EN(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .i_if_addr(i_if_addr), .i_if_bytes(i_if_bytes), .i_if_req(i_if_req),
    .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
    .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata), .i_mem_bytes(i_mem_bytes),
    .i_mem_op(i_mem_op), .i_mem_req(i_mem_req),
    .o_mem_rdata(o_mem_rdata), .o_mem_ack(o_mem_ack),
    .o_core_addr(o_core_addr), .o_core_wdata(o_core_wdata), .o_core_bytes(o_core_bytes),
    .o_core_op(o_core_op), .o_core_req(o_core_req),
    .i_core_rdata(i_core_rdata), .i_core_ack(i_core_ack),
    .i_arb_lock(i_arb_lock), .o_arb_busy(o_arb_busy), .o_arb_owner(o_arb_owner),
    .o_arb_timeout(o_arb_timeout), .i_timeout_clr(i_timeout_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic owner; logic [63:0] rdata; } resp_t;
  resp_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // requester-side copies of the fields each requester is presenting
  logic [63:0] if_addr_e, mem_addr_e, mem_wdata_e;
  logic [2:0]  if_bytes_e, mem_bytes_e;
  logic        mem_op_e;
  bit          if_granted, mem_granted;

  // core model and transaction-level arbitration model
  bit          core_active = 0, core_hold = 0, rdata_fixed = 0, rnd_done = 0;
  int          core_left, core_lat_fixed = -1, ncyc = 0;
  logic [63:0] rdata_next, rdata_cur;
  logic        exp_owner_cur, exp_op_cur, mdl_last = 1'b0;
  logic [63:0] exp_addr_cur, exp_wdata_cur;
  logic [2:0]  exp_bytes_cur;
  logic        if_log[4], mem_log[4], lock_log[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, "_addr"},  o_core_addr,  exp_addr_cur);
    chk({tag, "_wdata"}, o_core_wdata, exp_wdata_cur);
    chk({tag, "_bytes"}, 64'(o_core_bytes), 64'(exp_bytes_cur));
    chk({tag, "_op"},    64'(o_core_op),    64'(exp_op_cur));
  endtask

  // Arbitration decision made two cycles before core_req became visible
  task automatic grant_seen();
    int   s;
    logic o;
    s = (ncyc + 2) % 4;
    chk("lock_at_grant", lock_log[s], 0);
    chk("req_at_grant", if_log[s] | mem_log[s], 1);
    if (if_log[s] && mem_log[s]) o = ~mdl_last;
    else                         o = mem_log[s];
    mdl_last = o;
    exp_owner_cur = o;
    if (o) begin
      exp_addr_cur = mem_addr_e; exp_wdata_cur = mem_wdata_e;
      exp_bytes_cur = mem_bytes_e; exp_op_cur = mem_op_e; mem_granted = 1;
    end else begin
      exp_addr_cur = if_addr_e; exp_wdata_cur = '0;
      exp_bytes_cur = if_bytes_e; exp_op_cur = 1'b0; if_granted = 1;
    end
    chk("grant_owner", o_arb_owner, o);
    chk_fields("grant");
    core_left = (core_lat_fixed >= 0) ? core_lat_fixed : $urandom_range(0, 4);
    rdata_cur = rdata_fixed ? rdata_next : {$urandom, $urandom};
    core_active = 1;
  endtask

  initial begin : core_model
    i_core_ack = 0;
    i_core_rdata = '0;
    forever begin
      @(negedge clk);
      ncyc++;
      if_log[ncyc % 4] = i_if_req;
      mem_log[ncyc % 4] = i_mem_req;
      lock_log[ncyc % 4] = i_arb_lock;
      if (!rst) begin
        core_active = 0; i_core_ack = 0; mdl_last = 1'b0;
      end else if (i_core_ack) begin
        chk("core_req_drop", o_core_req, 0);
        i_core_ack = 0;
        core_active = 0;
      end else if (core_active) begin
        chk("core_req_hold", o_core_req, 1);
        if (!core_hold) begin
          if (core_left == 0) begin
            chk_fields("ack");
            i_core_rdata = rdata_cur;
            i_core_ack = 1;
            exp_q.push_back('{exp_owner_cur, rdata_cur});
          end else begin
            core_left--;
          end
        end
      end else if (o_core_req) begin
        grant_seen();
      end
    end
  end

  initial begin : monitor
    logic  prev_ack;
    resp_t e;
    prev_ack = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_ack = 0;
      end else begin
        if (o_if_ack || o_mem_ack) begin
          chk("ack_onehot", o_if_ack & o_mem_ack, 0);
          chk("ack_width", prev_ack, 0);
          chk("ack_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_owner", o_mem_ack, e.owner);
            chk("ack_rdata", e.owner ? o_mem_rdata : o_if_rdata, e.rdata);
          end
        end
        prev_ack = o_if_ack | o_mem_ack;
      end
    end
  end

  task automatic if_txn(input logic [63:0] a, input logic [2:0] b);
    int n;
    @(posedge clk); #1;
    if_addr_e = a; if_bytes_e = b; if_granted = 0;
    i_if_addr = a; i_if_bytes = b; i_if_req = 1;
    n = 0;
    while (n < BUDGET) begin
      @(negedge clk); n++;
      if (!rst || o_if_ack) break;
      if (if_granted) begin i_if_addr = {$urandom, $urandom}; i_if_bytes = 3'($urandom); end
    end
    if (rst) begin
      chk("if_ack_budget", n < BUDGET, 1);
      @(posedge clk); #1;
    end
    i_if_req = 0;
  endtask

  task automatic mem_txn(input logic [63:0] a, input logic [63:0] d, input logic [2:0] b, input logic op);
    int n;
    @(posedge clk); #1;
    mem_addr_e = a; mem_wdata_e = d; mem_bytes_e = b; mem_op_e = op; mem_granted = 0;
    i_mem_addr = a; i_mem_wdata = d; i_mem_bytes = b; i_mem_op = op; i_mem_req = 1;
    n = 0;
    while (n < BUDGET) begin
      @(negedge clk); n++;
      if (!rst || o_mem_ack) break;
      if (mem_granted) begin
        i_mem_addr = {$urandom, $urandom}; i_mem_wdata = {$urandom, $urandom};
        i_mem_bytes = 3'($urandom); i_mem_op = 1'($urandom);
      end
    end
    if (rst) begin
      chk("mem_ack_budget", n < BUDGET, 1);
      @(posedge clk); #1;
    end
    i_mem_req = 0;
  endtask

  task automatic wait_active();
    int n;
    n = 0;
    while (!core_active && n < BUDGET) begin @(negedge clk); #1; n++; end
    chk("wait_core_active", core_active, 1);
  endtask

  initial begin : guard
    #900000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin : main
    rst = 0;
    i_if_addr = '0; i_if_bytes = '0; i_if_req = 0;
    i_mem_addr = '0; i_mem_wdata = '0; i_mem_bytes = '0; i_mem_op = 0; i_mem_req = 0;
    i_arb_lock = 0; i_timeout_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_req", o_core_req, 0);
    chk("rst_if_ack", o_if_ack, 0);
    chk("rst_mem_ack", o_mem_ack, 0);
    chk("rst_busy", o_arb_busy, 0);
    chk("rst_owner", o_arb_owner, 0);
    chk("rst_timeout", o_arb_timeout, 0);
    chk("rst_core_addr", o_core_addr, 0);
    chk("rst_if_rdata", o_if_rdata, 0);
    @(negedge clk); rst = 1;

    // ties from reset history: MEM, then IF, then MEM again
    fork
      if_txn(64'h8000_1000, 3'd7);
      mem_txn(64'h8000_2000, 64'h11, 3'd3, 1'b0);
    join
    fork
      if_txn(64'h8000_1008, 3'd3);
      mem_txn(64'h8000_2008, 64'h22, 3'd1, 1'b1);
    join

    core_lat_fixed = 3; rdata_fixed = 1; rdata_next = 64'h1234;
    if_txn(64'h8000_0004, 3'd3);
    rdata_fixed = 0; core_lat_fixed = 4;
    mem_txn(64'h8000_000E, 64'hDEADBEEF_CAFEF00D, 3'd7, 1'b1);
    core_lat_fixed = 1;

    // lock held in IDLE with both pending
    @(posedge clk); #1; i_arb_lock = 1;
    fork
      if_txn(64'h8000_3000, 3'd0);
      mem_txn(64'h8000_4000, 64'h33, 3'd2, 1'b0);
      begin
        repeat (10) @(negedge clk);
        chk("lock_idle_core_req", o_core_req, 0);
        chk("lock_idle_busy", o_arb_busy, 0);
        @(posedge clk); #1; i_arb_lock = 0;
      end
    join

    // lock raised during WAIT lets the current access finish, then holds off MEM
    core_hold = 1;
    fork
      if_txn(64'h8000_5000, 3'd5);
      begin
        wait_active();
        @(posedge clk); #1; i_arb_lock = 1;
        repeat (3) @(posedge clk); #1; core_hold = 0;
        repeat (14) @(negedge clk);
        chk("lock_wait_core_req", o_core_req, 0);
        chk("lock_wait_busy", o_arb_busy, 0);
        chk("lock_wait_mem_pending", i_mem_req, 1);
        @(posedge clk); #1; i_arb_lock = 0;
      end
      begin
        wait_active();
        mem_txn(64'h8000_6000, 64'h44, 3'd6, 1'b1);
      end
    join

    // randomized traffic with sporadic lock
    core_lat_fixed = -1;
    fork
      begin
        fork
          for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            if_txn({$urandom, $urandom}, 3'($urandom));
          end
          for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            mem_txn({$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), 1'($urandom));
          end
        join
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          i_arb_lock = ($urandom_range(0, 9) == 0);
        end
        i_arb_lock = 0;
      end
    join
    chk("rand_no_timeout", o_arb_timeout, 0);

    // watchdog with a hung core
    core_hold = 1; core_lat_fixed = 0;
    fork
      if_txn(64'h8000_7000, 3'd7);
      begin
        wait_active();
        repeat (7) @(negedge clk);
        chk("wd_before_limit", o_arb_timeout, 0);
        @(negedge clk);
        chk("wd_at_limit", o_arb_timeout, 1);
        repeat (5) @(negedge clk);
        chk("wd_sticky", o_arb_timeout, 1);
        @(posedge clk); #1; i_timeout_clr = 1;
        @(posedge clk); #1; i_timeout_clr = 0;
        @(negedge clk);
        chk("wd_cleared", o_arb_timeout, 0);
        core_hold = 0;
        repeat (6) @(negedge clk);
        chk("wd_stays_clear", o_arb_timeout, 0);
      end
    join

    // asynchronous reset in the middle of WAIT
    core_hold = 1;
    fork
      if_txn(64'h8000_8000, 3'd1);
      begin
        wait_active();
        @(posedge clk); #3; rst = 0; #1;
        chk("arst_core_req", o_core_req, 0);
        chk("arst_if_ack", o_if_ack, 0);
        chk("arst_mem_ack", o_mem_ack, 0);
        chk("arst_busy", o_arb_busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1; core_hold = 0;
      end
    join
    core_lat_fixed = 2;
    if_txn(64'h8000_9000, 3'd4);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_210544_cache_arbiter.md
Name: ysyx_210544_cache_arbiter

Overview:
Two-requester arbiter that shares one unaligned-capable cache core port between instruction fetch (IF, read-only) and data memory (MEM, read/write). It sits between the pipeline's fetch/LSU stages and the cache core. It registers each granted request, holds it until the core acks, and returns the data with a one-cycle ack pulse to the owner. It also provides a lock input so cache-sync or flush sequences can quiesce the port, plus a watchdog that flags a hung core.

Parameters:
MEM_FIRST, 1, on a tie with no fairness history, grant MEM (1) or IF (0)
RR_EN, 1, 1 = alternate owner when both requesters are pending back-to-back; 0 = fixed priority per MEM_FIRST
TIMEOUT, 1023, core-ack watchdog limit in cycles (10-bit counter)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
i_if_addr  in  64  fetch address
i_if_bytes  in  3  fetch size, 0..7 encodes 1..8 bytes
i_if_req  in  1  fetch request, level-held until ack
o_if_rdata  out  64  fetch data, valid while o_if_ack=1
o_if_ack  out  1  one-cycle completion pulse
i_mem_addr  in  64  data address
i_mem_wdata  in  64  store data
i_mem_bytes  in  3  data size, 0..7 encodes 1..8 bytes
i_mem_op  in  1  0 = read, 1 = write
i_mem_req  in  1  data request, level-held until ack
o_mem_rdata  out  64  load data, valid while o_mem_ack=1
o_mem_ack  out  1  one-cycle completion pulse
o_core_addr  out  64  to cache core
o_core_wdata  out  64  to cache core
o_core_bytes  out  3  to cache core
o_core_op  out  1  to cache core
o_core_req  out  1  to cache core, registered
i_core_rdata  in  64  from cache core
i_core_ack  in  1  from cache core, registered pulse
i_arb_lock  in  1  block new grants
o_arb_busy  out  1  1 in any state other than IDLE
o_arb_owner  out  1  current or last owner: 0 = IF, 1 = MEM
o_arb_timeout  out  1  sticky watchdog flag
i_timeout_clr  in  1  clears o_arb_timeout

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0. Last-owner history=IF, so on the first tie MEM wins when MEM_FIRST=1. Watchdog counter=0.
- Reset asserted mid-transaction: o_core_req drops immediately; the in-flight core access is abandoned; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If i_arb_lock=1: stay in IDLE, no grant.
  - Otherwise pick an owner from the pending reqs.
    - Single requester: that requester wins.
    - Both pending with RR_EN=1: the requester that is not the last owner wins.
    - Both pending with RR_EN=0: MEM_FIRST decides.
  - On grant: latch addr/wdata/bytes/op into core-side registers (IF: op=0, wdata=0), set o_arb_owner, go to ISSUE.
- ISSUE: o_core_req<=1, go to WAIT. Result: o_core_req rises 2 cycles after the requester's req is first sampled.
- WAIT: hold o_core_req and the latched fields stable.
  - On i_core_ack=1: o_core_req<=0, capture i_core_rdata, go to RESP.
  - o_core_req falls the cycle after the ack, so the core sees req=1 with ack=1 and never restarts the access.
- RESP: drive the owner's ack=1 and rdata=captured data for exactly one cycle; the other ack stays 0; next state IDLE.
- Requester obligations:
  - Drop req on the edge after its ack.
  - The IDLE cycle after RESP guarantees a stale req is never re-granted.
  - Minimum turnaround is 4 cycles plus core latency.
- Request fields that change after grant are ignored (latched copy used).
- Lock semantics:
  - i_arb_lock is sampled only in IDLE.
  - Asserting it during ISSUE/WAIT/RESP does not abort; the current access completes.
  - o_arb_busy=0 together with i_arb_lock=1 means the port is quiescent.
- Watchdog:
  - Counter increments every WAIT cycle and clears on leaving WAIT.
  - Reaching TIMEOUT sets o_arb_timeout, which is sticky.
  - The transaction keeps waiting (no abort).
  - i_timeout_clr clears the flag; if the flag would set in the same cycle as clear, clear wins.
  - The counter saturates, never wraps.
- o_if_rdata/o_mem_rdata: hold the last captured value. They are meaningful only during the ack.

Decomposition:
- Shared defines file gets:
  - state encodings ARB_IDLE/ISSUE/WAIT/RESP (2 bits)
  - owner encodings OWNER_IF=0, OWNER_MEM=1
  - the 64-bit bus width define
- Sub-module ysyx_210544_arb_pick: combinational owner select from (if_req, mem_req, last_owner, RR_EN, MEM_FIRST). It is a small separate unit so it can be tested on its own.

Test Plan:
- IF-only read: if_req=1, addr=0x8000_0004, bytes=3; core acks 3 cycles after o_core_req, rdata=0x1234 -> o_core_op=0, o_if_ack pulses once with o_if_rdata=0x1234, o_mem_ack stays 0.
- Simultaneous reqs with RR_EN=1 from reset -> MEM granted first, then IF. Next tie -> MEM again, since last owner is IF. Both acks are exactly one cycle wide.
- MEM write: addr=0x8000_000E, bytes=7, wdata=0xDEADBEEF_CAFEF00D, op=1 -> core sees identical fields. Changing i_mem_wdata during WAIT does not alter o_core_wdata.
- Lock: i_arb_lock=1 in IDLE with both reqs -> o_core_req stays 0 and busy=0. Lock raised during WAIT -> transaction completes, then no further grant until lock drops.
- Watchdog with TIMEOUT=8: core never acks -> o_arb_timeout=1 after 8 WAIT cycles and stays 1. i_timeout_clr -> 0. Late ack still completes normally.
- Async reset during WAIT -> o_core_req=0 and all acks 0 immediately. After release, a fresh IF req is served normally.
